pause_ram_arbiter: RTL and testbench
====================================

# pause_ram_arbiter

Sequences CPU pause and shares the game work-RAM port between the CPU bus and the hiscore engine. It sits between the hiscore module and the game core, running on the system clock. A hiscore request first halts the CPU and waits for a frame boundary, then hands the RAM port to the hiscore engine, then returns it. The block also owns the user pause toggle, OSD pause and the idle-dim timer.

## Interface
Parameters:
- AW, 16, RAM address width
- DW, 8, RAM data width
- SETTLE_CYCLES, 4, clk_sys cycles between CPU halt and grant (≥1)
- DIM_CYCLES, 32'h1C9C3800, paused cycles before dim_video asserts (10 s at 48 MHz)

Ports:
- clk_sys  in  1  system clock (48 MHz)
- reset  in  1  asynchronous, active-high
- vblank  in  1  vertical blank level, clk_sys-synchronous
- pause_btn  in  1  user pause button level
- osd_open  in  1  OSD visible
- osd_pause_en  in  1  pause-on-OSD option enabled
- hs_req  in  1  hiscore engine requests RAM (level)
- hs_addr / hs_wdata / hs_we  in  AW / DW / 1  hiscore RAM bus
- cpu_addr / cpu_wdata / cpu_we  in  AW / DW / 1  CPU RAM bus
- ram_addr / ram_wdata / ram_we  out  AW / DW / 1  muxed RAM port
- hs_grant  out  1  RAM owned by hiscore
- cpu_pause  out  1  halt CPU
- dim_video  out  1  halve RGB

## Operation
- Pause toggle: a rising edge of pause_btn (registered previous value) inverts pause_toggle.
- cpu_pause = pause_toggle | (osd_open & osd_pause_en) | hs_hold, registered. hs_hold = 1 in every arbiter state except RUN.
- Arbiter FSM:
  - RUN → HALT_WAIT when hs_req = 1.
  - HALT_WAIT → SETTLE on a vblank rising edge. Also → SETTLE immediately if cpu_pause was already 1 because of the toggle or OSD at entry. → RUN if hs_req drops.
  - SETTLE: counter loads SETTLE_CYCLES−1 and counts down. → GRANT at 0. → RUN if hs_req drops.
  - GRANT: hs_grant = 1, RAM mux selects the hs_* bus. → RELEASE when hs_req drops.
  - RELEASE: one cycle with hs_grant = 0, mux back to CPU, cpu_pause still held by hs_hold. → RUN.
- RAM mux select is a registered flag equal to (state == GRANT). Outside GRANT, ram_we = cpu_we. In GRANT, cpu_we is ignored.
- Dim timer: a 32-bit counter increments while cpu_pause = 1 and saturates at DIM_CYCLES. It clears to 0 in the cycle cpu_pause = 0. dim_video = (count ≥ DIM_CYCLES).

## Timing
- Reset values: state RUN, pause_toggle 0, cpu_pause 0, hs_grant 0, dim_video 0, mux = CPU, dim count 0, edge registers 0.
- hs_req rising → cpu_pause high 1 cycle later.
- Grant latency from the qualifying vblank edge is exactly SETTLE_CYCLES + 1 cycles.
- hs_req falling in GRANT:
  - hs_grant low 1 cycle later (entering RELEASE).
  - cpu_pause (hiscore contribution) low 2 cycles later.
- ram_* outputs are combinational from the registered select. Address and data pass through with zero latency.
- Simultaneous events:
  - hs_req rising together with a vblank edge: the edge does not qualify. HALT_WAIT waits for the next edge.
  - Button edge during GRANT: toggle updates, arbitration is unaffected.
- Reset mid-GRANT: hs_grant and cpu_pause drop asynchronously and the mux returns to CPU.
- dim_video asserts on the cycle the count reaches DIM_CYCLES and drops 1 cycle after cpu_pause falls.

## Structure
- Shared package: arb_state_t enum (RUN, HALT_WAIT, SETTLE, GRANT, RELEASE) and DIM_CYCLES_48M constant.
- One sub-module: pause_dim_timer (saturating counter plus compare).
- FSM and mux stay in the top level.

## Test plan
- SETTLE_CYCLES=4, hs_req rises in active video, vblank rises 100 cycles later → cpu_pause at +1, hs_grant exactly 5 cycles after the vblank edge; ram_addr follows hs_addr = 16'hC000 with hs_we = 1.
- pause_toggle already 1, then hs_req rises → no vblank wait, hs_grant 5 cycles after HALT_WAIT entry; after hs_req drops, cpu_pause stays 1 (toggle held).
- hs_req drops during SETTLE count 2 → return to RUN, hs_grant never 1, cpu_pause 0 one cycle later.
- DIM_CYCLES=16, pause_btn pulse → dim_video 1 after 16 paused cycles; second pulse → cpu_pause 0, dim_video 0 the following cycle.
- Reset asserted in GRANT with cpu_we = 1, cpu_addr = 16'h1234 → hs_grant 0 immediately, ram_addr = 16'h1234, ram_we = 1, state RUN after release.
- osd_open = 1 with osd_pause_en = 0 → cpu_pause 0; set osd_pause_en = 1 → cpu_pause 1 next cycle.

Source files
------------

// File: rtl/pause_ram_arbiter_pkg.sv
// Shared types and constants for the pause / work-RAM arbiter.
package pause_ram_arbiter_pkg;

  typedef enum logic [2:0] {
    RUN,
    HALT_WAIT,
    SETTLE,
    GRANT,
    RELEASE
  } arb_state_t;

  // 10 s of paused time at 48 MHz
  localparam logic [31:0] DIM_CYCLES_48M = 32'h1C9C3800;

endpackage

// File: rtl/pause_dim_timer.sv
// Idle-dim timer: counts paused cycles and saturates at DIM_CYCLES.
module pause_dim_timer
  import pause_ram_arbiter_pkg::*;
#(
  parameter logic [31:0] DIM_CYCLES = DIM_CYCLES_48M
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_pause,
  output logic o_dim
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_pause) begin
      r_cnt <= '0;
    end else if (r_cnt < DIM_CYCLES) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_dim = (r_cnt >= DIM_CYCLES);

endmodule

// File: rtl/pause_ram_arbiter.sv
// CPU pause sequencing and work-RAM sharing between CPU and hiscore.
module pause_ram_arbiter
  import pause_ram_arbiter_pkg::*;
#(
  parameter int          AW            = 16,
  parameter int          DW            = 8,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [31:0] DIM_CYCLES    = DIM_CYCLES_48M
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          vblank,
  input  logic          pause_btn,
  input  logic          osd_open,
  input  logic          osd_pause_en,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  input  logic          hs_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          hs_grant,
  output logic          cpu_pause,
  output logic          dim_video
);

  arb_state_t  r_state;
  arb_state_t  w_nxt;
  logic        r_btn_q;
  logic        r_vbl_q;
  logic        r_toggle;
  logic        r_cpu_pause;
  logic        r_sel;
  logic [31:0] r_settle;
  logic        w_vbl_rise;
  logic        w_btn_rise;
  logic        w_osd_pause;
  logic        w_ext_pause;
  logic        w_toggle_nxt;

  assign w_vbl_rise   = vblank & ~r_vbl_q;
  assign w_btn_rise   = pause_btn & ~r_btn_q;
  assign w_osd_pause  = osd_open & osd_pause_en;
  assign w_ext_pause  = r_toggle | w_osd_pause;
  assign w_toggle_nxt = r_toggle ^ w_btn_rise;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (hs_req) w_nxt = HALT_WAIT;
      end
      HALT_WAIT: begin
        if (!hs_req)
          w_nxt = RUN;
        else if (w_vbl_rise || w_ext_pause)
          w_nxt = SETTLE;
      end
      SETTLE: begin
        if (!hs_req)
          w_nxt = RUN;
        else if (r_settle == '0)
          w_nxt = GRANT;
      end
      GRANT: begin
        if (!hs_req) w_nxt = RELEASE;
      end
      RELEASE: w_nxt = RUN;
      default: w_nxt = RUN;
    endcase
  end

  // Settle counter sits preloaded outside SETTLE
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_btn_q     <= 1'b0;
      r_vbl_q     <= 1'b0;
      r_toggle    <= 1'b0;
      r_cpu_pause <= 1'b0;
      r_sel       <= 1'b0;
      r_settle    <= 32'(SETTLE_CYCLES - 1);
    end else begin
      r_state     <= w_nxt;
      r_btn_q     <= pause_btn;
      r_vbl_q     <= vblank;
      r_toggle    <= w_toggle_nxt;
      r_cpu_pause <= w_toggle_nxt | w_osd_pause
                   | (w_nxt != RUN);
      r_sel       <= (w_nxt == GRANT);
      if (r_state != SETTLE)
        r_settle <= 32'(SETTLE_CYCLES - 1);
      else if (r_settle != '0)
        r_settle <= r_settle - 32'd1;
    end
  end

  assign ram_addr  = r_sel ? hs_addr  : cpu_addr;
  assign ram_wdata = r_sel ? hs_wdata : cpu_wdata;
  assign ram_we    = r_sel ? hs_we    : cpu_we;
  assign hs_grant  = r_sel;
  assign cpu_pause = r_cpu_pause;

  pause_dim_timer #(
    .DIM_CYCLES(DIM_CYCLES)
  ) u_dim (
    .clk_sys(clk_sys),
    .reset  (reset),
    .i_pause(r_cpu_pause),
    .o_dim  (dim_video)
  );

endmodule

// File: tb/tb_pause_ram_arbiter.sv
// Bench for pause_ram_arbiter: directed tables, sequences, random vs model.
module tb_pause_ram_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int SC  = 4;
  localparam int DIM = 16;

  logic          clk_sys;
  logic          reset;
  logic          vblank;
  logic          pause_btn;
  logic          osd_open;
  logic          osd_pause_en;
  logic          hs_req;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_wdata;
  logic          hs_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          hs_grant;
  logic          cpu_pause;
  logic          dim_video;

  pause_ram_arbiter #(
    .AW(AW), .DW(DW),
    .SETTLE_CYCLES(SC),
    .DIM_CYCLES(32'(DIM))
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .vblank(vblank), .pause_btn(pause_btn),
    .osd_open(osd_open),
    .osd_pause_en(osd_pause_en),
    .hs_req(hs_req), .hs_addr(hs_addr),
    .hs_wdata(hs_wdata), .hs_we(hs_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we),
    .hs_grant(hs_grant), .cpu_pause(cpu_pause),
    .dim_video(dim_video)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting frame,
  // 2 settling, 3 granted, 4 releasing.
  int          m_phase;
  int          m_wait;
  int unsigned m_cnt;
  bit          m_tog, m_pause, m_grant;
  bit          m_pbtn, m_pvbl;

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_cnt = 0;
    m_tog = 0; m_pause = 0; m_grant = 0;
    m_pbtn = 0; m_pvbl = 0;
  endtask

  task automatic model_edge();
    bit osdp, ext, vrise;
    int np;
    osdp  = osd_open && osd_pause_en;
    ext   = m_tog || osdp;
    vrise = vblank && !m_pvbl;
    np    = m_phase;
    case (m_phase)
      0: if (hs_req) np = 1;
      1: if (!hs_req) np = 0;
         else if (vrise || ext) begin
           np = 2; m_wait = SC - 1;
         end
      2: if (!hs_req) np = 0;
         else if (m_wait == 0) np = 3;
         else m_wait = m_wait - 1;
      3: if (!hs_req) np = 4;
      default: np = 0;
    endcase
    if (!m_pause) m_cnt = 0;
    else if (m_cnt < DIM) m_cnt = m_cnt + 1;
    if (pause_btn && !m_pbtn) m_tog = !m_tog;
    m_phase = np;
    m_pause = m_tog || osdp || (np != 0);
    m_grant = (np == 3);
    m_pbtn  = pause_btn;
    m_pvbl  = vblank;
  endtask

  task automatic model_chk();
    logic [27:0] a, e;
    a = {hs_grant, cpu_pause, dim_video,
         ram_we, ram_wdata, ram_addr};
    e = {m_grant, m_pause, (m_cnt >= DIM),
         m_grant ? hs_we    : cpu_we,
         m_grant ? hs_wdata : cpu_wdata,
         m_grant ? hs_addr  : cpu_addr};
    chk("model", 64'(a), 64'(e));
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    #1;
    model_chk();
  endtask

  typedef struct packed {
    logic osd;
    logic en;
    logic hs;
    logic pause;
    logic grant;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int k;
    tbl[0]  = '{1,0,0, 0,0};
    tbl[1]  = '{1,1,0, 1,0};
    tbl[2]  = '{1,1,0, 1,0};
    tbl[3]  = '{0,1,0, 0,0};
    tbl[4]  = '{1,1,1, 1,0};
    tbl[5]  = '{1,1,1, 1,0};
    tbl[6]  = '{1,1,1, 1,0};
    tbl[7]  = '{1,1,1, 1,0};
    tbl[8]  = '{1,1,1, 1,0};
    tbl[9]  = '{1,1,1, 1,1};
    tbl[10] = '{1,1,0, 1,0};
    tbl[11] = '{0,0,0, 0,0};

    reset = 1; vblank = 0; pause_btn = 0;
    osd_open = 0; osd_pause_en = 0; hs_req = 0;
    hs_addr = 16'hC000; hs_wdata = 8'h5A;
    hs_we = 1; cpu_addr = 16'h0100;
    cpu_wdata = 8'h11; cpu_we = 0;
    model_reset();
    #3;
    chk("rst_grant", hs_grant, 0);
    chk("rst_pause", cpu_pause, 0);
    chk("rst_dim", dim_video, 0);
    chk("rst_addr", ram_addr, 16'h0100);
    @(posedge clk_sys); #1;
    reset = 0;
    tick();

    // frame-synchronised grant
    hs_req = 1;
    tick();
    chk("req_pause", cpu_pause, 1);
    k = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (hs_grant) k++;
    end
    chk("no_early_grant", k, 0);
    vblank = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("vbl_lat", hs_grant, (i == 5));
    end
    chk("hs_addr", ram_addr, 16'hC000);
    chk("hs_we", ram_we, 1);
    chk("hs_wdata", ram_wdata, 8'h5A);
    vblank = 0;
    hs_req = 0;
    tick();
    chk("rel_grant", hs_grant, 0);
    chk("rel_pause", cpu_pause, 1);
    chk("rel_addr", ram_addr, 16'h0100);
    tick();
    chk("run_pause", cpu_pause, 0);

    // already paused by toggle: no frame wait
    pause_btn = 1; tick();
    pause_btn = 0;
    chk("tog_pause", cpu_pause, 1);
    hs_req = 1; tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("tog_lat", hs_grant, (i == 5));
    end
    hs_req = 0; tick(); tick();
    chk("tog_held", cpu_pause, 1);
    pause_btn = 1; tick();
    pause_btn = 0;
    chk("tog_off", cpu_pause, 0);
    tick();

    // abort during settle
    hs_req = 1; tick();
    vblank = 1; tick();
    tick();
    hs_req = 0; vblank = 0; tick();
    chk("abort_pause", cpu_pause, 0);
    chk("abort_grant", hs_grant, 0);
    tick();

    // idle dim
    pause_btn = 1; tick();
    pause_btn = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i >= 15)
        chk("dim_on", dim_video, (i == 16));
    end
    pause_btn = 1; tick();
    pause_btn = 0;
    chk("dim_unpause", cpu_pause, 0);
    tick();
    chk("dim_off", dim_video, 0);

    // osd pause and grant latency table
    for (int i = 0; i < 12; i++) begin
      osd_open     = tbl[i].osd;
      osd_pause_en = tbl[i].en;
      hs_req       = tbl[i].hs;
      tick();
      chk($sformatf("tbl%0d_pause", i),
          cpu_pause, tbl[i].pause);
      chk($sformatf("tbl%0d_grant", i),
          hs_grant, tbl[i].grant);
    end

    // reset while granted
    hs_req = 1; tick();
    vblank = 1;
    k = 0;
    while (!hs_grant && k < 20) begin
      tick(); k++;
    end
    chk("grant_wait", hs_grant, 1);
    vblank = 0;
    cpu_we = 1; cpu_addr = 16'h1234; hs_we = 0;
    #1;
    chk("cpu_we_ignored", ram_we, 0);
    #1;
    reset = 1;
    #1;
    chk("arst_grant", hs_grant, 0);
    chk("arst_pause", cpu_pause, 0);
    chk("arst_addr", ram_addr, 16'h1234);
    chk("arst_we", ram_we, 1);
    model_reset();
    hs_req = 0;
    #1;
    reset = 0;
    tick();
    chk("arst_run", {hs_grant, cpu_pause}, 0);

    // randomized against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) hs_req = ~hs_req;
      if ($urandom_range(49) == 0)
        pause_btn = ~pause_btn;
      if ($urandom_range(149) == 0)
        osd_open = ~osd_open;
      if ($urandom_range(199) == 0)
        osd_pause_en = ~osd_pause_en;
      vblank    = (c % 60) >= 50;
      hs_addr   = AW'($urandom);
      hs_wdata  = DW'($urandom);
      hs_we     = 1'($urandom);
      cpu_addr  = AW'($urandom);
      cpu_wdata = DW'($urandom);
      cpu_we    = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
